// File: rtl/axis_rr_packet_arbiter.sv
// rtl/axis_rr_packet_arbiter.sv - round-robin AXI-Stream arbiter merging NUM_PORTS sources into one sink
// Define ARB_PKT_LOCK_EN to hold the grant for a whole packet; otherwise arbitration rotates every beat.
module axis_rr_packet_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]                s_axis_tlast,
    input  logic [NUM_PORTS-1:0]                s_axis_tvalid,
    output logic [NUM_PORTS-1:0]                s_axis_tready,
    output logic [DATA_WIDTH-1:0]               m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]             m_axis_tkeep,
    output logic                                m_axis_tlast,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic [$clog2(NUM_PORTS)-1:0]        grant_id,
    output logic                                busy
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_WIDTH  = $clog2(NUM_PORTS);

    typedef logic [IDX_WIDTH-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        PKT  = 2'd2
    } state_t;

    state_t state;
    state_t state_n;
    idx_t   gnt;
    idx_t   gnt_n;
    idx_t   ptr;
    idx_t   ptr_n;
    idx_t   sel;
    idx_t   idx;
    logic   any_valid;
    logic   acc;
    logic   last_eff;

    function automatic idx_t wrap_add(input idx_t base, input int off);
        int sum;
        sum = (int'(base) + off) % NUM_PORTS;
        return idx_t'(sum);
    endfunction

    // Rotating priority search: the port after the last-served one wins.
    always_comb begin
        sel       = ptr;
        any_valid = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (!any_valid && s_axis_tvalid[wrap_add(ptr, k)]) begin
                any_valid = 1'b1;
                sel       = wrap_add(ptr, k);
            end
        end
    end

    // While a beat is presented but stalled, the selection is frozen in gnt.
    assign idx = (state == IDLE) ? sel : gnt;

    assign m_axis_tdata  = s_axis_tdata[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
    assign m_axis_tkeep  = s_axis_tkeep[int'(idx)*KEEP_WIDTH +: KEEP_WIDTH];
    assign m_axis_tlast  = s_axis_tlast[idx];
    assign m_axis_tvalid = !rst && s_axis_tvalid[idx];

    always_comb begin
        s_axis_tready = '0;
        if (!rst && (state != IDLE || any_valid)) begin
            s_axis_tready[idx] = m_axis_tready;
        end
    end

    assign grant_id = (state == IDLE && any_valid) ? sel : gnt;
    assign busy     = (state != IDLE);
    assign acc      = m_axis_tvalid && m_axis_tready;

`ifdef ARB_PKT_LOCK_EN
    assign last_eff = m_axis_tlast;
`else
    assign last_eff = 1'b1;
`endif

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        ptr_n   = ptr;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    if (acc) begin
                        ptr_n = sel;
                        if (!last_eff) begin
                            state_n = PKT;
                            gnt_n   = sel;
                        end
                    end else begin
                        state_n = HOLD;
                        gnt_n   = sel;
                    end
                end
            end
            HOLD: begin
                if (acc) begin
                    ptr_n   = gnt;
                    state_n = last_eff ? IDLE : PKT;
                end
            end
            PKT: begin
                // Valid gaps from the granted source keep the grant.
                if (acc && last_eff) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= idx_t'(NUM_PORTS - 1);
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            ptr   <= ptr_n;
        end
    end

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// tb/tb_axis_rr_packet_arbiter.sv - scoreboard bench for axis_rr_packet_arbiter
module tb_axis_rr_packet_arbiter;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int IW = $clog2(NP);

`ifdef ARB_PKT_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NP*DW-1:0] s_tdata = '0;
    logic [NP*KW-1:0] s_tkeep = '0;
    logic [NP-1:0]    s_tlast = '0;
    logic [NP-1:0]    s_tvalid = '0;
    logic [NP-1:0]    s_tready;
    logic [DW-1:0]    m_tdata;
    logic [KW-1:0]    m_tkeep;
    logic             m_tlast;
    logic             m_tvalid;
    logic             m_tready = 1'b0;
    logic [IW-1:0]    grant_id;
    logic             busy;

    always #5 clk = ~clk;

    axis_rr_packet_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    beat_t src_q[NP][$];
    beat_t exp_q[NP][$];
    int    start_cyc[NP];
    int    seq[NP];
    int    unit_cnt[NP];
    int    order_q[$];
    int    exp_order[$];
    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;
    bit    rst_req = 1'b1;
    int    rdy_mode = 0;
    int    stall_left = 0;
    bit    refill = 1'b0;
    // reference arbiter state: 0 idle, 1 hold, 2 packet
    int    mst = 0;
    int    mgnt = 0;
    int    mptr = NP - 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_pkt(input int p, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = {p[7:0], seq[p][23:0]};
            b.keep = KW'($urandom_range(1, (1 << KW) - 1));
            b.last = (i == len - 1);
            seq[p]++;
            src_q[p].push_back(b);
            exp_q[p].push_back(b);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int p = 0; p < NP; p++) s += exp_q[p].size();
        return s;
    endfunction

    task automatic drive();
        rst = rst_req;
        for (int p = 0; p < NP; p++) begin
            if (refill) begin
                while (src_q[p].size() < 6) push_pkt(p, $urandom_range(1, 4));
            end
            if (src_q[p].size() > 0 && cyc >= start_cyc[p]) begin
                s_tvalid[p]           = 1'b1;
                s_tdata[p*DW +: DW]   = src_q[p][0].data;
                s_tkeep[p*KW +: KW]   = src_q[p][0].keep;
                s_tlast[p]            = src_q[p][0].last;
            end else begin
                s_tvalid[p]           = 1'b0;
                s_tdata[p*DW +: DW]   = $urandom;
                s_tkeep[p*KW +: KW]   = KW'($urandom);
                s_tlast[p]            = 1'($urandom_range(0, 1));
            end
        end
        case (rdy_mode)
            0: m_tready = 1'b1;
            1: m_tready = 1'($urandom_range(0, 1));
            default: begin
                if (stall_left > 0) begin
                    m_tready = 1'b0;
                    stall_left--;
                end else begin
                    m_tready = 1'b1;
                end
            end
        endcase
    endtask

    task automatic sample();
        int          e;
        bit          any;
        bit          acc;
        bit          lastb;
        beat_t       b;
        logic [NP-1:0] er;
        any = |s_tvalid;
        e   = mgnt;
        if (mst == 0 && any) begin
            for (int k = 1; k <= NP; k++) begin
                if (s_tvalid[(mptr + k) % NP]) begin
                    e = (mptr + k) % NP;
                    break;
                end
            end
        end
        er = '0;
        if (!rst && (mst != 0 || any)) er[e] = m_tready;
        check("m_tvalid", m_tvalid, !rst && s_tvalid[e]);
        check("s_tready", s_tready, er);
        check("grant_id", grant_id, e);
        check("busy", busy, mst != 0);
        acc   = !rst && s_tvalid[e] && m_tready;
        lastb = LOCK ? s_tlast[e] : 1'b1;
        if (acc) begin
            b = exp_q[e].pop_front();
            void'(src_q[e].pop_front());
            check("tdata", m_tdata, b.data);
            check("tkeep", m_tkeep, b.keep);
            check("tlast", m_tlast, b.last);
            order_q.push_back(e);
            if (!LOCK || b.last) unit_cnt[e]++;
        end
        if (rst) begin
            mst = 0; mgnt = 0; mptr = NP - 1;
        end else begin
            case (mst)
                0: if (any) begin
                    if (acc && lastb) mptr = e;
                    else if (acc) begin mst = 2; mgnt = e; mptr = e; end
                    else begin mst = 1; mgnt = e; end
                end
                1: if (acc) begin mptr = mgnt; mst = lastb ? 0 : 2; end
                default: if (acc && lastb) mst = 0;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        sample();
        cyc++;
    endtask

    task automatic flush();
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            exp_q[p].delete();
            start_cyc[p] = 0;
        end
        order_q.delete();
        exp_order.delete();
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        step();
        step();
        flush();
        rst_req = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        int pend;
        pend = pending();
        while (pend > 0 && n < budget) begin
            step();
            n++;
            pend = pending();
        end
        check(tag, pend, 0);
    endtask

    task automatic check_order(input string tag);
        check({tag, "_len"}, order_q.size(), exp_order.size());
        for (int i = 0; i < order_q.size() && i < exp_order.size(); i++) begin
            check(tag, order_q[i], exp_order[i]);
        end
    endtask

    initial begin
        int n;
        int total;
        int mn;
        int mx;
        for (int p = 0; p < NP; p++) begin
            start_cyc[p] = 0;
            seq[p]       = 0;
            unit_cnt[p]  = 0;
        end

        do_reset();
        step();
        check("rst_grant", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_tready", s_tready, 0);
        check("rst_tvalid", m_tvalid, 0);

        // two sources with single-beat packets alternate
        push_pkt(0, 1); push_pkt(0, 1);
        push_pkt(2, 1); push_pkt(2, 1);
        drain("t1_drain", 50);
        exp_order = '{0, 2, 0, 2};
        check_order("t1_order");

        // port 3 joins while port 1 is mid-packet
        do_reset();
        push_pkt(1, 4);
        push_pkt(3, 1);
        start_cyc[3] = cyc + 1;
        drain("t2_drain", 50);
`ifdef ARB_PKT_LOCK_EN
        exp_order = '{1, 1, 1, 1, 3};
`else
        exp_order = '{1, 3, 1, 1, 1};
`endif
        check_order("t2_order");

        // stalled sink with a later requester: presented source must not change
        do_reset();
        rdy_mode   = 2;
        stall_left = 3;
        push_pkt(2, 1);
        push_pkt(0, 1);
        start_cyc[0] = cyc + 1;
        drain("t3_drain", 50);
        exp_order = '{2, 0};
        check_order("t3_order");
        rdy_mode = 0;

        // reset in the middle of a port 3 packet
        do_reset();
        push_pkt(3, 4);
        n = 0;
        while (order_q.size() < 2 && n < 20) begin
            step();
            n++;
        end
        check("t4_progress", order_q.size(), 2);
        rst_req = 1'b1;
        step();
        flush();
        push_pkt(0, 1);
        push_pkt(3, 1);
        rst_req = 1'b0;
        step();
        check("t4_grant", grant_id, 0);
        check("t4_busy", busy, 0);
        drain("t4_drain", 50);
        exp_order = '{0, 3};
        check_order("t4_order");

        // two 3-beat packets
        do_reset();
        push_pkt(0, 3);
        push_pkt(1, 3);
        drain("t5_drain", 50);
`ifdef ARB_PKT_LOCK_EN
        exp_order = '{0, 0, 0, 1, 1, 1};
`else
        exp_order = '{0, 1, 0, 1, 0, 1};
`endif
        check_order("t5_order");

        // all ports saturated with random sink backpressure
        do_reset();
        for (int p = 0; p < NP; p++) unit_cnt[p] = 0;
        rdy_mode = 1;
        refill   = 1'b1;
        n        = 0;
        total    = 0;
        while (total < 1000 && n < 40000) begin
            step();
            n++;
            total = 0;
            for (int p = 0; p < NP; p++) total += unit_cnt[p];
        end
        check("t6_progress", total >= 1000, 1);
        mn = unit_cnt[0];
        mx = unit_cnt[0];
        for (int p = 1; p < NP; p++) begin
            if (unit_cnt[p] < mn) mn = unit_cnt[p];
            if (unit_cnt[p] > mx) mx = unit_cnt[p];
        end
        check("t6_fair", (mx - mn) <= 1, 1);
        refill   = 1'b0;
        rdy_mode = 0;
        drain("t6_drain", 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
